// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB codes and burst-length helper for the arbiter slice.
package ahb_arbiter_pkg;

  localparam int unsigned MAX_MASTER = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Number of address phases in a burst; undefined-length INCR counts as 1
  // so that it stays preemptible after every beat.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    len = 5'd1;
    case (hburst_e'(hburst))
      HBURST_SINGLE: len = 5'd1;
      HBURST_INCR:   len = 5'd1;
      HBURST_WRAP4:  len = 5'd4;
      HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8:  len = 5'd8;
      HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16: len = 5'd16;
      HBURST_INCR16: len = 5'd16;
      default:       len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arb_rr.sv
// Combinational round-robin picker: first requester above 'last', wrapping,
// with 'last' itself considered at the very end.
module ahb_arb_rr
  import ahb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTER = 2
) (
  input  logic [NUM_MASTER-1:0] req,
  input  logic [3:0]            last,
  output logic [NUM_MASTER-1:0] gnt,
  output logic [3:0]            idx,
  output logic                  any
);

  logic [MAX_MASTER-1:0] req_ext;
  logic [MAX_MASTER-1:0] gnt_ext;
  logic [3:0]            cand;
  logic                  found;

  assign req_ext = MAX_MASTER'(req);

  // Scan offsets 1..NUM_MASTER from 'last'; offset NUM_MASTER is the owner.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_MASTER; k++) begin
      cand = 4'((32'(last) + k) % NUM_MASTER);
      if (!found && req_ext[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  // One-hot form of the chosen index, empty when nobody requests.
  always_comb begin
    gnt_ext = '0;
    if (found) gnt_ext[idx] = 1'b1;
  end

  assign gnt = gnt_ext[NUM_MASTER-1:0];
  assign any = |req;

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin, burst-aware, lock-aware, parks on
// DEFAULT_MASTER when the bus is idle.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTER     = 2,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_MASTER-1:0] HBUSREQ,
  input  logic [NUM_MASTER-1:0] HLOCK,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic                  HREADY,
  output logic [NUM_MASTER-1:0] HGRANT,
  output logic [3:0]            HMASTER,
  output logic                  HMASTLOCK
);

  localparam logic [3:0]            DEF_IDX     = 4'(DEFAULT_MASTER);
  localparam logic [MAX_MASTER-1:0] DEF_GNT_EXT = MAX_MASTER'(1) << DEFAULT_MASTER;
  localparam logic [NUM_MASTER-1:0] DEF_GNT     = DEF_GNT_EXT[NUM_MASTER-1:0];

  logic [3:0]            gidx;       // index of the current HGRANT holder
  logic [3:0]            cnt;        // remaining address phases of fixed burst
  logic [3:0]            cnt_next;
  logic [MAX_MASTER-1:0] lock_ext;
  logic                  owner_lock;
  logic                  arb_ok;

  logic [NUM_MASTER-1:0] pick_gnt;
  logic [3:0]            pick_idx;
  logic                  pick_any;
  logic [NUM_MASTER-1:0] nxt_gnt;
  logic [3:0]            nxt_idx;

  assign lock_ext   = MAX_MASTER'(HLOCK);
  assign owner_lock = lock_ext[gidx];

  // Round-robin pointer is the current grant holder: the winner always
  // becomes the new holder, so a separate pointer register would mirror gidx.
  ahb_arb_rr #(
    .NUM_MASTER (NUM_MASTER)
  ) u_rr (
    .req  (HBUSREQ),
    .last (gidx),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next grant: round-robin winner, or park on the default master.
  always_comb begin
    nxt_gnt = DEF_GNT;
    nxt_idx = DEF_IDX;
    if (pick_any) begin
      nxt_gnt = pick_gnt;
      nxt_idx = pick_idx;
    end
  end

  // Beat counter next value; only an accepted transfer changes it.
  always_comb begin
    cnt_next = cnt;
    if (HREADY) begin
      case (htrans_e'(HTRANS))
        HTRANS_NONSEQ: cnt_next = 4'(burst_len(HBURST) - 5'd1);
        HTRANS_SEQ:    if (cnt != '0) cnt_next = cnt - 4'd1;
        default:       cnt_next = cnt;
      endcase
    end
  end

  assign arb_ok = !owner_lock && (cnt_next == '0);

  // Grant, ownership and beat-counter registers; wait states freeze all.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HGRANT    <= DEF_GNT;
      gidx      <= DEF_IDX;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      cnt       <= '0;
    end else if (HREADY) begin
      cnt       <= cnt_next;
      HMASTER   <= gidx;
      HMASTLOCK <= owner_lock;
      if (arb_ok) begin
        HGRANT <= nxt_gnt;
        gidx   <= nxt_idx;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot(HGRANT))
    else $error("HGRANT not one-hot: %b", HGRANT);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Randomised scoreboard bench for ahb_arbiter (4 masters, default 0).
module tb_ahb_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned D = 0;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [N-1:0]  HBUSREQ;
  logic [N-1:0]  HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [N-1:0]  HGRANT;
  logic [3:0]    HMASTER;
  logic          HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(
    .NUM_MASTER     (N),
    .DEFAULT_MASTER (D)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [3:0]   mst;
    logic         lck;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: who holds the grant, who owns the address phase,
  // and how many address phases of the current fixed burst remain.
  int unsigned m_g   = D;
  int unsigned m_mst = D;
  int unsigned m_rem = 0;
  bit          m_lck = 1'b0;
  int unsigned len_tab[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  function automatic bit bit_of(input logic [N-1:0] v, input int unsigned i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_edge();
    int unsigned rem;
    int unsigned w;
    bit          f;
    if (!HRESETn) begin
      m_g = D; m_mst = D; m_lck = 1'b0; m_rem = 0;
    end else if (HREADY) begin
      rem = m_rem;
      if (HTRANS == 2'd2) rem = len_tab[HBURST] - 1;
      else if (HTRANS == 2'd3 && m_rem > 0) rem = m_rem - 1;
      m_mst = m_g;
      m_lck = bit_of(HLOCK, m_g);
      if (!bit_of(HLOCK, m_g) && rem == 0) begin
        w = D; f = 1'b0;
        for (int unsigned k = 1; k <= N; k++)
          if (!f && bit_of(HBUSREQ, (m_g + k) % N)) begin
            w = (m_g + k) % N; f = 1'b1;
          end
        m_g = w;
      end
      m_rem = rem;
    end
  endtask

  // Drive one cycle of inputs, model the edge, queue the expected outputs.
  task automatic cyc(input logic rst_n, input logic [N-1:0] req, input logic [N-1:0] lck,
                     input logic [1:0] trans, input logic [2:0] burst, input logic rdy);
    exp_t e;
    HRESETn = rst_n; HBUSREQ = req; HLOCK = lck;
    HTRANS = trans; HBURST = burst; HREADY = rdy;
    @(posedge HCLK);
    model_edge();
    e.gnt = N'(1) << m_g;
    e.mst = 4'(m_mst);
    e.lck = m_lck;
    sbq.push_back(e);
    @(negedge HCLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents new outputs; compare with the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty: no expected entry at time %0t", $time);
      end else begin
        e = sbq.pop_front();
        if (HGRANT !== e.gnt || HMASTER !== e.mst || HMASTLOCK !== e.lck) begin
          n_bad++;
          $display("FAIL sb @%0t: got gnt=%b mst=%0d lck=%b required gnt=%b mst=%0d lck=%b",
                   $time, HGRANT, HMASTER, HMASTLOCK, e.gnt, e.mst, e.lck);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] lk;
    // Reset held for 5 cycles, then released with no requests.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, '0, 2'd0, 3'd0, 1'b1);
      chk("rst_gnt", 32'(HGRANT), 32'h1);
      chk("rst_mst", 32'(HMASTER), 32'h0);
      chk("rst_lck", 32'(HMASTLOCK), 32'h0);
    end
    cyc(1'b1, '0, '0, 2'd0, 3'd0, 1'b1);
    chk("park_gnt", 32'(HGRANT), 32'h1);

    // Fixed INCR8 by master0; master1 requests from beat 2.
    cyc(1'b1, 4'b0001, '0, 2'd2, 3'd5, 1'b1);
    for (int i = 2; i <= 7; i++) cyc(1'b1, 4'b0011, '0, 2'd3, 3'd5, 1'b1);
    chk("incr8_beat7_gnt", 32'(HGRANT), 32'h1);
    cyc(1'b1, 4'b0011, '0, 2'd3, 3'd5, 1'b1);
    chk("incr8_beat8_gnt", 32'(HGRANT), 32'h2);
    chk("incr8_beat8_mst", 32'(HMASTER), 32'h0);
    cyc(1'b1, 4'b0010, '0, 2'd0, 3'd0, 1'b1);
    chk("handover_mst", 32'(HMASTER), 32'h1);

    // Master1 locked over two INCR4 bursts while master0 requests.
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, 4'b0011, 4'b0010, (i == 0) ? 2'd2 : 2'd3, 3'd3, 1'b1);
        chk("lock_gnt", 32'(HGRANT), 32'h2);
        chk("lock_mlk", 32'(HMASTLOCK), 32'h1);
      end
    cyc(1'b1, 4'b0011, '0, 2'd0, 3'd0, 1'b1);
    chk("unlock_gnt", 32'(HGRANT), 32'h1);

    // Reset during beat 3 of a master1 WRAP16.
    cyc(1'b1, 4'b0010, '0, 2'd0, 3'd0, 1'b1);
    cyc(1'b1, 4'b0010, '0, 2'd0, 3'd0, 1'b1);
    cyc(1'b1, 4'b0010, '0, 2'd2, 3'd6, 1'b1);
    cyc(1'b1, 4'b0010, '0, 2'd3, 3'd6, 1'b1);
    cyc(1'b0, 4'b0010, '0, 2'd3, 3'd6, 1'b1);
    chk("midrst_gnt", 32'(HGRANT), 32'h1);
    chk("midrst_mst", 32'(HMASTER), 32'h0);
    cyc(1'b1, 4'b0010, '0, 2'd0, 3'd0, 1'b1);
    chk("midrst_nostale", 32'(HGRANT), 32'h2);

    // All masters requesting with SINGLE NONSEQ: rotate 1,2,3,0,...
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'b1111, '0, 2'd2, 3'd0, 1'b1);

    // Randomised traffic with wait states, locks and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      lk = '0;
      for (int b = 0; b < int'(N); b++) lk[b] = ($urandom_range(0, 7) == 0);
      cyc(($urandom_range(0, 99) != 0), N'($urandom), lk,
          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 4) != 0));
    end

    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
